// File: rtl/univ_shift_reg_if.sv
// Bus bundle for univ_shift_reg.
// The master drives the control and data inputs and observes the register outputs;
// the slave (the register itself) does the reverse.
//   en      update enable
//   mode    3-bit operation select
//   d       parallel load data
//   sin_l   serial input into the MSB on SHR
//   sin_r   serial input into the LSB on SHL
//   q       register contents
//   qbar    bitwise complement of q
//   sout_l  MSB tap
//   sout_r  LSB tap
interface univ_shift_reg_if #(
  parameter int unsigned WIDTH = 8
);
  logic             en;
  logic [2:0]       mode;
  logic [WIDTH-1:0] d;
  logic             sin_l;
  logic             sin_r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qbar;
  logic             sout_l;
  logic             sout_r;

  modport master (
    output en, mode, d, sin_l, sin_r,
    input  q, qbar, sout_l, sout_r
  );

  modport slave (
    input  en, mode, d, sin_l, sin_r,
    output q, qbar, sout_l, sout_r
  );
endinterface

// File: rtl/univ_shift_reg.sv
// Universal WIDTH-bit shift register with complementary outputs.
// Modes: hold, parallel load, logical shift left/right, rotate left/right,
// arithmetic shift right and synchronous clear.
// An asynchronous active-low reset loads RESET_VAL.
//   clk    rising-edge clock
//   rst_n  asynchronous reset, active low
//   bus    slave side of univ_shift_reg_if:
//            en, mode, d, sin_l, sin_r in; q, qbar, sout_l, sout_r out
// The interface WIDTH must match this module's WIDTH.
module univ_shift_reg #(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic            clk,
  input logic            rst_n,
  univ_shift_reg_if.slave bus
);

  typedef enum logic [2:0] {
    ModeHold = 3'b000,
    ModeLoad = 3'b001,
    ModeShl  = 3'b010,
    ModeShr  = 3'b011,
    ModeRol  = 3'b100,
    ModeRor  = 3'b101,
    ModeAsr  = 3'b110,
    ModeClr  = 3'b111
  } mode_e;

  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_q;

  always_comb begin
    q_d = q_q;
    if (bus.en) begin
      case (mode_e'(bus.mode))
        ModeHold: q_d = q_q;
        ModeLoad: q_d = bus.d;
        ModeShl:  q_d = {q_q[WIDTH-2:0], bus.sin_r};
        ModeShr:  q_d = {bus.sin_l, q_q[WIDTH-1:1]};
        ModeRol:  q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        ModeRor:  q_d = {q_q[0], q_q[WIDTH-1:1]};
        ModeAsr:  q_d = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
        // Clear goes to zero, not to the reset value.
        ModeClr:  q_d = '0;
        default:  q_d = q_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= RESET_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  // All outputs are pure functions of the register, so qbar tracks q without
  // any intermediate state where they could coincide.
  assign bus.q      = q_q;
  assign bus.qbar   = ~q_q;
  assign bus.sout_l = q_q[WIDTH-1];
  assign bus.sout_r = q_q[0];

endmodule
